// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: word/step constants, queue entry width and
// the fetch FSM state encoding.
package riscv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Queue entry layout: {instr, pc, fault}.
  localparam int FETCH_ENTRY_W = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular FIFO with push/pop/flush. Flush wins over push and pop.
// The head register is shown even when empty; consumers qualify it with valid_o.
module fetch_queue #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [1:0]   count_o,
  output logic         valid_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// RV32 fetch controller: owns the PC, reads imem, queues {instr, pc, fault}.
// Define FETCH_ALIGN_CHECK_EN for the alignment/bounds check build with HALT.
module instr_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_count,
  output logic        dbg_pc_oob
);

  localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

  fetch_state_t             state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              redirect_target;
  logic [1:0]               q_count;
  logic                     q_valid;
  logic [FETCH_ENTRY_W-1:0] q_head;
  logic                     push;
  logic                     pop;
  logic                     can_push;
  logic                     fault_now;
  logic                     entry_fault;
  logic [31:0]              entry_instr;

  // Handshake: an entry moves to decode on every cycle where fetch_valid and
  // fetch_ready are both high; head outputs hold while valid is high and ready low.
  assign pop      = q_valid & fetch_ready;
  assign can_push = (q_count != 2'd2) || pop;

  assign dbg_pc_oob = ({1'b0, pc_q[31:2]} >= MEM_LIMIT);

`ifdef FETCH_ALIGN_CHECK_EN
  // Keep the raw target so a fault entry can report the offending address.
  assign redirect_target = redirect_pc;
  assign fault_now       = (pc_q[1:0] != 2'b00) || dbg_pc_oob;
`else
  assign redirect_target = redirect_pc & PC_ALIGN_MASK;
  assign fault_now       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    push        = 1'b0;
    entry_fault = 1'b0;
    entry_instr = imem_instr;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (can_push) begin
          push = 1'b1;
          if (fault_now) begin
            entry_fault = 1'b1;
            entry_instr = INSTR_NOP;
            state_d     = HALT;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    // Redirect overrides everything: flush, retarget, no push this cycle.
    if (redirect_valid) begin
      push        = 1'b0;
      entry_fault = 1'b0;
      state_d     = RUN;
      pc_d        = redirect_target;
    end
  end

  fetch_queue #(
    .W (FETCH_ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({entry_instr, pc_q, entry_fault}),
    .count_o (q_count),
    .valid_o (q_valid),
    .head_o  (q_head)
  );

  assign imem_addr   = pc_q & PC_ALIGN_MASK;
  assign fetch_valid = q_valid;
  assign fetch_instr = q_head[FETCH_ENTRY_W-1 -: 32];
  assign fetch_pc    = q_head[32:1];
  assign fetch_fault = q_head[0];
  assign dbg_state   = state_q;
  assign dbg_count   = q_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed + random bench for instr_fetch_ctrl against a queue-of-PCs model.
// Memory word k holds 32'h1000_0000 + k.
module tb_instr_fetch_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_WORDS = 512;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_fault;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;
  logic        dbg_pc_oob;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_instr = word_at(imem_addr);

  instr_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count),
    .dbg_pc_oob     (dbg_pc_oob)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [32:0] exp_q[$];   // {pc, fault} in decode order
  logic [31:0] mdl_pc;
  bit          mdl_boot;
  bit          mdl_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  imem_addr, RESET_PC);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_instr"}, fetch_instr, 32'd0);
    chk({tag, "_pc"},    fetch_pc, 32'd0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(BOOT));
    chk({tag, "_count"}, 32'(dbg_count), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_pc   = RESET_PC;
    mdl_boot = 1'b1;
    mdl_halt = 1'b0;
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
  endfunction

  task automatic model_update(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit pop;
    pop = rdy && (exp_q.size() != 0);
    if (redir) begin
      exp_q.delete();
      mdl_pc   = CHECK_EN ? rpc : (rpc & 32'hFFFF_FFFC);
      mdl_boot = 1'b0;
      mdl_halt = 1'b0;
    end else if (mdl_boot) begin
      mdl_boot = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (!mdl_halt && exp_q.size() < 2) begin
        if (CHECK_EN && addr_bad(mdl_pc)) begin
          exp_q.push_back({mdl_pc, 1'b1});
          mdl_halt = 1'b1;
        end else begin
          exp_q.push_back({mdl_pc, 1'b0});
          mdl_pc = mdl_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [32:0] head;
    logic [1:0]  exp_state;
    exp_state = mdl_boot ? 2'(BOOT) : (mdl_halt ? 2'(HALT) : 2'(RUN));
    chk("imem_addr", imem_addr, mdl_pc & 32'hFFFF_FFFC);
    chk("valid", 32'(fetch_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(dbg_count), 32'(exp_q.size()));
    chk("state", 32'(dbg_state), 32'(exp_state));
    chk("pc_oob", 32'(dbg_pc_oob), 32'((mdl_pc >> 2) >= 32'(MEM_WORDS)));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("head_pc", fetch_pc, head[32:1]);
      chk("head_instr", fetch_instr, head[0] ? INSTR_NOP : word_at(head[32:1]));
      chk("head_fault", 32'(fetch_fault), 32'(head[0]));
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at a falling edge: drive, check settled outputs, advance.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    fetch_ready    = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(redir, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    fetch_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    model_reset();

    // Streaming with decode always ready.
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1);

    mid_reset();

    // Backpressure right after restart.
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
    chk("bp_count", 32'(dbg_count), 32'd2);
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_head", fetch_pc, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Redirect with a full queue.
    step(1'b0, 32'd0, 1'b0);
    chk("pre_redir_count", 32'(dbg_count), 32'd2);
    step(1'b1, 32'h0000_0100, 1'b0);
    chk("redir_bubble_valid", 32'(fetch_valid), 32'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("redir_tgt_valid", 32'(fetch_valid), 32'd1);
    chk("redir_tgt_pc", fetch_pc, 32'h0000_0100);
    chk("redir_tgt_instr", fetch_instr, 32'h1000_0040);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned target produces a fault entry and halts fetch.
    step(1'b1, 32'h0000_0102, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("fault_valid", 32'(fetch_valid), 32'd1);
    chk("fault_flag", 32'(fetch_fault), 32'd1);
    chk("fault_pc", fetch_pc, 32'h0000_0102);
    chk("fault_instr", fetch_instr, 32'h0000_0013);
    chk("fault_state", 32'(dbg_state), 32'(HALT));
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("halt_drained", 32'(fetch_valid), 32'd0);
    step(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
`endif

    // Random redirects with ready toggling every cycle.
    for (int i = 0; i < 200; i++) begin
      bit          r;
      logic [31:0] a;
      r = ($urandom_range(0, 9) == 0);
      a = 32'($urandom_range(0, 4095));
      step(r, a, i[0]);
    end

    mid_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch controller for the RV32 core. It owns the program counter, drives the word address into the combinational-read instruction memory and captures each returned instruction with its PC into a 2-entry fetch queue. It presents the queue head to decode through a valid/ready handshake and handles branch/jump redirects by flushing the queue. It sits between the instruction memory and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `MEM_WORDS`, default 512: instruction memory depth in words; used only by the alignment/bounds check.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `imem_addr` output 32: byte address to instruction memory; bits [1:0] are always 0.
- `imem_instr` input 32: instruction word read combinationally at `imem_addr`, same cycle.
- `redirect_valid` input 1: branch/jump taken; one-cycle pulse.
- `redirect_pc` input 32: redirect target.
- `fetch_valid` output 1: queue head holds an instruction.
- `fetch_ready` input 1: decode accepts the head this cycle.
- `fetch_instr` output 32: queue head instruction.
- `fetch_pc` output 32: PC of the queue head.
- `fetch_fault` output 1: head entry is a fault marker (check build only, else tied 0).

## Operation
- States: `BOOT`, `RUN`, `HALT`. Reset enters `BOOT`. `BOOT` goes to `RUN` unconditionally after one cycle. `HALT` is reachable only in the check build.
- Registers: `pc_q` (next fetch address), queue entries {instr, pc, fault}, `count` (0..2).
- `imem_addr` = `pc_q`.
- Push condition: state `RUN`, no redirect, and (`count` < 2 or pop this cycle).
- On push, the {`imem_instr`, `pc_q`} pair is written to the tail and `pc_q` <= `pc_q` + 4.
- `pc_q` wraps modulo 2^32.
- Pop happens when `fetch_valid` && `fetch_ready`; the head advances.
- Push and pop in the same cycle with `count`==2 is legal; `count` stays 2.
- Push and pop in the same cycle with `count`==1 keeps `count` at 1; the new entry becomes the head.
- Redirect has the highest priority. `count` <= 0, `pc_q` <= {`redirect_pc`[31:2], 2'b00}, no push that cycle. A pop in that cycle is still honoured toward decode, but the entry is discarded.
- A redirect in `BOOT` updates `pc_q` and the state still moves to `RUN`.
- Reset mid-operation: all state clears immediately, asynchronously; in-flight entries are lost.

## Timing
- Reset values: `imem_addr`=`RESET_PC`, `fetch_valid`=0, `fetch_instr`=0, `fetch_pc`=0, `fetch_fault`=0, state `BOOT`, `count`=0.
- First push occurs in the first `RUN` cycle (cycle 2 after reset release). `fetch_valid` rises in cycle 3.
- Fetch-to-decode latency is 1 cycle: an instruction read in cycle N is on `fetch_instr` in cycle N+1.
- Redirect in cycle N: `fetch_valid`=0 in N+1, target fetched in N+1, target on `fetch_instr` with `fetch_valid`=1 in N+2. This is a 2-cycle bubble.
- With `fetch_ready` held 1, throughput is 1 instruction per cycle.
- While `fetch_valid`=1 and `fetch_ready`=0, the head outputs hold stable.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A `redirect_pc` with bits [1:0]≠0, or `pc_q`[31:2] ≥ `MEM_WORDS`, at push time pushes an entry with fault=1, instr=32'h0000_0013 (NOP) and pc=the offending address.
  - The FSM then enters `HALT`, where no further pushes occur.
  - Only a redirect or reset leaves `HALT`; the redirect returns to `RUN`.
- `FETCH_ALIGN_CHECK_EN` undefined: bits [1:0] are silently dropped, addresses are not bounds-checked, `fetch_fault` is tied 0, and `HALT` does not exist.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `INSTR_NOP`=32'h0000_0013, `PC_STEP`=4, and the `fetch_state_t` enum (`BOOT`, `RUN`, `HALT`).
- Sub-module `fetch_queue`: 2-entry FIFO with push/pop/flush, `count` and head outputs, parameterised on entry width.
- `instr_fetch_ctrl` holds the FSM, `pc_q` and the check logic.

## Test plan
- Reset release with `fetch_ready`=1, memory holding word k = 32'h1000_0000+k: `fetch_pc` reads 0,4,8,… from cycle 3, `fetch_instr` matches, and there are no gaps.
- Backpressure: hold `fetch_ready`=0 for 5 cycles after the first valid. `count` saturates at 2, `pc_q` stops at 8, and the head stays at pc 0. On release, pcs continue 0,4,8,12 with no loss or duplication.
- Redirect to 32'h0000_0100 while `count`=2: `fetch_valid`=0 next cycle, then `fetch_pc`=0x100 with word 64, and the stale entries never appear.
- Redirect with `fetch_ready` toggling every cycle, plus a simultaneous push/pop at `count`=2: check ordering against a reference PC model over 200 random cycles.
- Assert `rst_n`=0 mid-stream for half a cycle: outputs go to their reset values asynchronously and fetch restarts at `RESET_PC`.
- `FETCH_ALIGN_CHECK_EN` build, redirect to 32'h0000_0102: a fault entry appears with pc 0x102 and instr 0x13, the FSM enters `HALT`, and `fetch_valid` drops after pop. A redirect to 0x200 resumes fetch.
